// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for a 5-stage MIPS
// pipeline. It produces the PC write enable, the IF/ID load enable and flush,
// the ID/EX bubble select and the back-end freeze. It resolves load-use
// hazards, branch-operand hazards, taken branches and jumps, and data-cache
// miss stalls. It also keeps saturating stall and flush counters and a sticky
// cache-wait watchdog.
//
// The strobes are combinational from the state and the inputs, so they take
// effect in the same cycle. The state, the pending-flush flag, the wait
// counter, the watchdog flag and the performance counters are registered.
//
// Priority while out of reset:
//   1. dcache miss  : freeze everything and hold PC and IF/ID.
//   2. pend_flush   : a redirect seen during a miss flushes IF/ID in the
//                     first cycle after the miss ends.
//   3. hz           : hold PC and IF/ID and bubble ID/EX. Any redirect waits.
//   4. redirect     : take the new PC and flush the wrong-path fetch.
//   5. normal flow.
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             IsBranch_i,
  input  logic             BranchTaken_i,
  input  logic             IsJump_i,
  input  logic             IDEX_MemRead_i,
  input  logic             IDEX_RegWrite_i,
  input  logic [4:0]       IDEX_Rd_i,
  input  logic             EXMEM_MemRead_i,
  input  logic [4:0]       EXMEM_Rd_i,
  input  logic             dcache_stall_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             MemFreeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_timeout_o,
  // Debug view: current FSM state (0 = RUN, 1 = MEM_WAIT) and pending flush.
  output logic             dbg_state_o,
  output logic             dbg_pend_flush_o
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // The wait counter only needs to reach MAX_WAIT. It saturates there.
  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic pc_write, ifid_write, ifid_flush, idex_bubble, mem_freeze;
  logic load_use, br_ex, br_mem, hz, redirect;

  // Register r is non-zero and is read by the instruction in ID.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  // Hazard and redirect terms for the instruction in ID.
  always_comb begin
    load_use = IDEX_MemRead_i & reg_match(IDEX_Rd_i, IFID_Rs_i, IFID_Rt_i);
    br_ex    = IsBranch_i & IDEX_RegWrite_i
               & reg_match(IDEX_Rd_i, IFID_Rs_i, IFID_Rt_i);
    br_mem   = IsBranch_i & EXMEM_MemRead_i
               & reg_match(EXMEM_Rd_i, IFID_Rs_i, IFID_Rt_i);
    hz       = load_use | br_ex | br_mem;
    redirect = (IsBranch_i & BranchTaken_i) | IsJump_i;
  end

  // Next state and pipeline strobes. A miss freezes the pipeline in either
  // state. Once the miss clears, the cycle follows the normal-flow rules, so
  // no extra bubble is added on the way out of MEM_WAIT.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mem_freeze  = 1'b0;
    state_d     = state_q;
    pend_d      = pend_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;

    if (!rst_i) begin
      // Hold the front end and feed bubbles while reset is asserted.
      idex_bubble = 1'b1;
    end else if (dcache_stall_i) begin
      mem_freeze = 1'b1;
      state_d    = MEM_WAIT;
      if (state_q == RUN) begin
        // The redirect target is already held in the PC mux. Flush the
        // fetched instruction once the miss is over.
        if (redirect && !hz) begin
          pend_d = 1'b1;
        end
        wait_d = WAIT_ONE;
      end else if (wait_q != WAIT_MAX) begin
        wait_d = wait_q + WAIT_ONE;
      end
      if (wait_d == WAIT_MAX) begin
        timeout_d = 1'b1;
      end
    end else begin
      state_d = RUN;
      wait_d  = '0;
      if (pend_q) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        pend_d     = 1'b0;
      end else if (hz) begin
        idex_bubble = 1'b1;
      end else if (redirect) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  // FSM state, pending flush, cache-wait counter and sticky watchdog.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= RUN;
      pend_q    <= 1'b0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Saturating stall counter (cycles with PC held) and flush counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      if (ifid_flush && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign PCWrite_o        = pc_write;
  assign IFID_Write_o     = ifid_write;
  assign IFID_Flush_o     = ifid_flush;
  assign IDEX_Bubble_o    = idex_bubble;
  assign MemFreeze_o      = mem_freeze;
  assign stall_cnt_o      = stall_q;
  assign flush_cnt_o      = flush_q;
  assign mem_timeout_o    = timeout_q;
  assign dbg_state_o      = state_q;
  assign dbg_pend_flush_o = pend_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change on the falling edge.
// Combinational strobes are sampled 2 ns later. Registered values are sampled
// on the falling edge after the rising edge that updates them. A second
// instance with 3-bit counters and MAX_WAIT=3 shares the inputs, so counter
// saturation can be reached quickly.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ifid_rs, ifid_rt, idex_rd, exmem_rd;
  logic       is_branch, branch_taken, is_jump;
  logic       idex_mem_read, idex_reg_write, exmem_mem_read, dcache_stall;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, mem_freeze;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_timeout, dbg_state, dbg_pend;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_mem_freeze;
  logic [2:0]  s_stall_cnt, s_flush_cnt;
  logic        s_mem_timeout, s_dbg_state, s_dbg_pend;

  int checks = 0;
  int errors = 0;

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .MAX_WAIT(255)) dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt),
    .IsBranch_i(is_branch), .BranchTaken_i(branch_taken), .IsJump_i(is_jump),
    .IDEX_MemRead_i(idex_mem_read), .IDEX_RegWrite_i(idex_reg_write),
    .IDEX_Rd_i(idex_rd), .EXMEM_MemRead_i(exmem_mem_read), .EXMEM_Rd_i(exmem_rd),
    .dcache_stall_i(dcache_stall),
    .PCWrite_o(pc_write), .IFID_Write_o(ifid_write), .IFID_Flush_o(ifid_flush),
    .IDEX_Bubble_o(idex_bubble), .MemFreeze_o(mem_freeze),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mem_timeout_o(mem_timeout),
    .dbg_state_o(dbg_state), .dbg_pend_flush_o(dbg_pend)
  );

  pipe_hazard_ctrl #(.CNT_W(3), .MAX_WAIT(3)) dut_small (
    .clk_i(clk), .rst_i(rst),
    .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt),
    .IsBranch_i(is_branch), .BranchTaken_i(branch_taken), .IsJump_i(is_jump),
    .IDEX_MemRead_i(idex_mem_read), .IDEX_RegWrite_i(idex_reg_write),
    .IDEX_Rd_i(idex_rd), .EXMEM_MemRead_i(exmem_mem_read), .EXMEM_Rd_i(exmem_rd),
    .dcache_stall_i(dcache_stall),
    .PCWrite_o(s_pc_write), .IFID_Write_o(s_ifid_write), .IFID_Flush_o(s_ifid_flush),
    .IDEX_Bubble_o(s_idex_bubble), .MemFreeze_o(s_mem_freeze),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .mem_timeout_o(s_mem_timeout),
    .dbg_state_o(s_dbg_state), .dbg_pend_flush_o(s_dbg_pend)
  );

  task automatic clear_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rd = 5'd0; exmem_rd = 5'd0;
    is_branch = 1'b0; branch_taken = 1'b0; is_jump = 1'b0;
    idex_mem_read = 1'b0; idex_reg_write = 1'b0; exmem_mem_read = 1'b0;
    dcache_stall = 1'b0;
  endtask

  // Hold reset for two rising edges and release it on a falling edge.
  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reset asserted with a miss and a jump present: strobes at reset values.
  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    dcache_stall = 1'b1; is_jump = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pcwrite got=%0b exp=0", pc_write); end
    checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL rst_ifidwrite got=%0b exp=0", ifid_write); end
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%0b exp=0", ifid_flush); end
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble got=%0b exp=1", idex_bubble); end
    checks++; if (mem_freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze got=%0b exp=0", mem_freeze); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    checks++; if (mem_timeout !== 1'b0 || dbg_state !== 1'b0) begin errors++; $display("FAIL rst_state got=%0b/%0b exp=0/0", mem_timeout, dbg_state); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID: one bubble cycle.
  task automatic test_load_use();
    apply_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd2; ifid_rs = 5'd2; ifid_rt = 5'd4;
    #2;
    checks++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b0010) begin errors++; $display("FAIL lu_strobes got=%b exp=0010", {pc_write, ifid_write, idex_bubble, ifid_flush}); end
    @(negedge clk);
    idex_mem_read = 1'b0; idex_rd = 5'd0;
    #2;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin errors++; $display("FAIL lu_resume got=%b exp=110", {pc_write, ifid_write, idex_bubble}); end
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stallcnt got=%0d exp=1", stall_cnt); end
  endtask

  // Register $0 never creates a hazard, for loads or for branch operands.
  task automatic test_zero_reg();
    apply_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    #2;
    checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL zero_lw got=%b%b exp=10", pc_write, idex_bubble); end
    @(negedge clk);
    idex_mem_read = 1'b0; idex_reg_write = 1'b1; is_branch = 1'b1;
    exmem_mem_read = 1'b1; exmem_rd = 5'd0;
    #2;
    checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL zero_br got=%b%b exp=10", pc_write, idex_bubble); end
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL zero_stallcnt got=%0d exp=0", stall_cnt); end
  endtask

  // beq $5,$6 behind lw $5: bubble in EX, bubble in MEM, then taken -> flush.
  task automatic test_branch();
    apply_reset();
    is_branch = 1'b1; branch_taken = 1'b1; ifid_rs = 5'd5; ifid_rt = 5'd6;
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd5;
    #2;
    checks++; if ({pc_write, idex_bubble, ifid_flush} !== 3'b010) begin errors++; $display("FAIL br_c1 got=%b exp=010", {pc_write, idex_bubble, ifid_flush}); end
    @(negedge clk);
    idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_rd = 5'd0;
    exmem_mem_read = 1'b1; exmem_rd = 5'd5;
    #2;
    checks++; if ({pc_write, idex_bubble, ifid_flush} !== 3'b010) begin errors++; $display("FAIL br_c2 got=%b exp=010", {pc_write, idex_bubble, ifid_flush}); end
    @(negedge clk);
    exmem_mem_read = 1'b0; exmem_rd = 5'd0;
    #2;
    checks++; if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b1110) begin errors++; $display("FAIL br_c3 got=%b exp=1110", {pc_write, ifid_write, ifid_flush, idex_bubble}); end
    @(negedge clk);
    clear_inputs();
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin errors++; $display("FAIL br_counts got=%0d/%0d exp=1/2", flush_cnt, stall_cnt); end
  endtask

  // Four-cycle miss with a taken jump in ID: freeze 4, then one flush.
  task automatic test_cache_jump();
    apply_reset();
    is_jump = 1'b1; dcache_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if ({mem_freeze, pc_write, ifid_write, ifid_flush, idex_bubble} !== 5'b10000) begin errors++; $display("FAIL cj_freeze%0d got=%b exp=10000", i, {mem_freeze, pc_write, ifid_write, ifid_flush, idex_bubble}); end
      @(negedge clk);
    end
    checks++; if (dbg_state !== 1'b1 || dbg_pend !== 1'b1) begin errors++; $display("FAIL cj_state got=%b%b exp=11", dbg_state, dbg_pend); end
    dcache_stall = 1'b0;
    #2;
    checks++; if ({mem_freeze, pc_write, ifid_write, ifid_flush} !== 4'b0111) begin errors++; $display("FAIL cj_flush got=%b exp=0111", {mem_freeze, pc_write, ifid_write, ifid_flush}); end
    @(negedge clk);
    is_jump = 1'b0;
    #2;
    checks++; if (ifid_flush !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL cj_after got=%b%b exp=01", ifid_flush, pc_write); end
    @(negedge clk);
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd4 || mem_timeout !== 1'b0) begin errors++; $display("FAIL cj_counts got=%0d/%0d/%0b exp=1/4/0", flush_cnt, stall_cnt, mem_timeout); end
  endtask

  // A jump blocked by a load-use hazard during a miss must not be remembered.
  task automatic test_cache_hz();
    apply_reset();
    is_jump = 1'b1; dcache_stall = 1'b1;
    idex_mem_read = 1'b1; idex_rd = 5'd7; ifid_rs = 5'd7;
    @(negedge clk);
    dcache_stall = 1'b0;
    #2;
    checks++; if ({idex_bubble, ifid_flush, pc_write} !== 3'b100) begin errors++; $display("FAIL chz_nopend got=%b exp=100", {idex_bubble, ifid_flush, pc_write}); end
    @(negedge clk);
    idex_mem_read = 1'b0;
    #2;
    checks++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL chz_redir got=%b%b exp=11", ifid_flush, pc_write); end
    @(negedge clk);
    clear_inputs();
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin errors++; $display("FAIL chz_counts got=%0d/%0d exp=1/2", flush_cnt, stall_cnt); end
  endtask

  // A 300-cycle miss: the watchdog sets after the 255th stalled edge and stays set.
  task automatic test_timeout();
    apply_reset();
    dcache_stall = 1'b1;
    for (int i = 0; i < 254; i++) @(negedge clk);
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_early got=%0b exp=0", mem_timeout); end
    @(negedge clk);
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_rise got=%0b exp=1", mem_timeout); end
    for (int i = 0; i < 45; i++) @(negedge clk);
    dcache_stall = 1'b0;
    #2;
    checks++; if (pc_write !== 1'b1 || mem_freeze !== 1'b0) begin errors++; $display("FAIL to_exit got=%b%b exp=10", pc_write, mem_freeze); end
    @(negedge clk);
    checks++; if (mem_timeout !== 1'b1 || stall_cnt !== 16'd300 || dbg_state !== 1'b0) begin errors++; $display("FAIL to_final got=%0b/%0d/%0b exp=1/300/0", mem_timeout, stall_cnt, dbg_state); end
    checks++; if (s_stall_cnt !== 3'd7 || s_mem_timeout !== 1'b1) begin errors++; $display("FAIL to_small got=%0d/%0b exp=7/1", s_stall_cnt, s_mem_timeout); end
  endtask

  // Asynchronous reset in the middle of MEM_WAIT.
  task automatic test_reset_mid_wait();
    dcache_stall = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++; if (dbg_state !== 1'b1 || stall_cnt !== 16'd305) begin errors++; $display("FAIL rmw_pre got=%0b/%0d exp=1/305", dbg_state, stall_cnt); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({pc_write, ifid_write, ifid_flush, idex_bubble, mem_freeze} !== 5'b00010) begin errors++; $display("FAIL rmw_strobes got=%b exp=00010", {pc_write, ifid_write, ifid_flush, idex_bubble, mem_freeze}); end
    checks++; if (dbg_state !== 1'b0 || stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL rmw_regs got=%0b/%0d/%0b exp=0/0/0", dbg_state, stall_cnt, mem_timeout); end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #2;
    checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL rmw_release got=%b%b exp=10", pc_write, idex_bubble); end
    @(negedge clk);
    checks++; if (dbg_state !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rmw_after got=%0b/%0d/%0d exp=0/0/0", dbg_state, stall_cnt, flush_cnt); end
  endtask

  // Back-to-back jumps: a flush on every cycle, and the small flush counter saturates.
  task automatic test_back_to_back();
    apply_reset();
    is_jump = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL b2b_flush%0d got=%b%b exp=11", i, ifid_flush, pc_write); end
      @(negedge clk);
    end
    is_jump = 1'b0;
    checks++; if (flush_cnt !== 16'd10 || s_flush_cnt !== 3'd7 || s_stall_cnt !== 3'd0) begin errors++; $display("FAIL b2b_counts got=%0d/%0d/%0d exp=10/7/0", flush_cnt, s_flush_cnt, s_stall_cnt); end
    dcache_stall = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    dcache_stall = 1'b0;
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd10 || s_stall_cnt !== 3'd7) begin errors++; $display("FAIL b2b_sat got=%0d/%0d exp=10/7", stall_cnt, s_stall_cnt); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_cache_jump();
    test_cache_hz();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the PC write enable, the IF/ID write-enable and flush, and the ID/EX bubble select.
- Resolves load-use hazards, branch-operand hazards, taken branches and jumps, and data-cache miss stalls.
- Sits beside the ID stage and keeps saturating stall and flush counters plus a cache-wait watchdog.

Parameters:
CNT_W, 16, width of the performance counters
MAX_WAIT, 255, number of MEM_WAIT cycles after which mem_timeout_o sets

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
IFID_Rs_i  in  5  rs field of the instruction in ID
IFID_Rt_i  in  5  rt field of the instruction in ID
IsBranch_i  in  1  instruction in ID is a branch; compares rs/rt in ID
BranchTaken_i  in  1  branch comparison in ID resolved taken
IsJump_i  in  1  instruction in ID is a jump
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_RegWrite_i  in  1  instruction in EX writes a register
IDEX_Rd_i  in  5  destination register of the instruction in EX (already muxed)
EXMEM_MemRead_i  in  1  instruction in MEM is a load
EXMEM_Rd_i  in  5  destination register of the instruction in MEM
dcache_stall_i  in  1  data cache miss in progress
PCWrite_o  out  1  PC update enable
IFID_Write_o  out  1  IF/ID register load enable
IFID_Flush_o  out  1  IF/ID loads a NOP (32'd0)
IDEX_Bubble_o  out  1  zero the control fields entering ID/EX
MemFreeze_o  out  1  freeze the ID/EX, EX/MEM and MEM/WB registers
stall_cnt_o  out  CNT_W  stall cycles; saturating
flush_cnt_o  out  CNT_W  flushes issued; saturating
mem_timeout_o  out  1  sticky cache-wait watchdog flag

Behaviour:
Hazard terms:
- match(r) = (r != 0) & (r == IFID_Rs_i | r == IFID_Rt_i).
- load_use = IDEX_MemRead_i & match(IDEX_Rd_i).
- br_ex = IsBranch_i & IDEX_RegWrite_i & match(IDEX_Rd_i).
- br_mem = IsBranch_i & EXMEM_MemRead_i & match(EXMEM_Rd_i).
- hz = load_use | br_ex | br_mem.
- redirect = (IsBranch_i & BranchTaken_i) | IsJump_i.

FSM states:
- RUN (reset state), MEM_WAIT.
- Outputs are combinational from state and inputs: zero-cycle latency. State, counters and flags are registered.

RUN:
- dcache_stall_i=1 (highest priority): PCWrite_o=0, IFID_Write_o=0, MemFreeze_o=1, IDEX_Bubble_o=0. Next state MEM_WAIT. If redirect & !hz, set pend_flush.
- else hz=1: PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1. Any redirect is ignored; the branch re-evaluates next cycle.
- else redirect=1: PCWrite_o=1, IFID_Write_o=1, IFID_Flush_o=1.
- else: PCWrite_o=1, IFID_Write_o=1, all other strobes 0.
- If pend_flush=1 on entry to RUN, the first RUN cycle asserts IFID_Flush_o=1 with PCWrite_o=1, then clears pend_flush. The PC target is already held in the PC mux. A new dcache_stall_i in that cycle still wins; pend_flush stays set.

MEM_WAIT:
- Same outputs as the RUN miss case.
- wait_cnt increments each cycle. When wait_cnt reaches MAX_WAIT, mem_timeout_o sets and stays set until reset.
- When dcache_stall_i=0: return to RUN and clear wait_cnt. No extra bubble is inserted.

Counters:
- stall_cnt_o += 1 on every cycle with PCWrite_o=0.
- flush_cnt_o += 1 on every cycle with IFID_Flush_o=1.
- Both saturate at all-ones and never wrap.

Reset:
- rst_i=0, including mid-MEM_WAIT: state=RUN, pend_flush=0, wait_cnt=0, counters=0, mem_timeout_o=0.
- While rst_i=0: PCWrite_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_Bubble_o=1, MemFreeze_o=0.
- After release, outputs follow RUN rules from the first edge.

Test Plan:
- lw $2 in EX (IDEX_MemRead_i=1, IDEX_Rd_i=2), ID add $3,$2,$4 -> one cycle with PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; stall_cnt_o=1.
- lw $0 in EX, ID uses $0 -> no stall; PCWrite_o=1.
- beq $5,$6 with lw $5 in EX -> cycle 1 bubble (load_use/br_ex), cycle 2 bubble (br_mem, EXMEM_Rd_i=5), cycle 3 BranchTaken_i=1 -> IFID_Flush_o=1; flush_cnt_o=1, stall_cnt_o=2.
- dcache_stall_i high 4 cycles while ID holds a taken jump -> MemFreeze_o=1 for 4 cycles; next cycle IFID_Flush_o=1 once; no mem_timeout_o.
- dcache_stall_i held 300 cycles with MAX_WAIT=255 -> mem_timeout_o rises at wait cycle 255 and stays 1 after the stall ends; stall_cnt_o=300.
- rst_i low mid-MEM_WAIT -> all outputs at reset values asynchronously; after release, state RUN and counters 0. Separately, force stall_cnt_o to all-ones and stall again -> value holds, no wrap.
